// File: rtl/ctrl_decode_pipe.sv
// Registered ID/EX control decoder: opcode/mode decode, ARM condition gating,
// branch-shadow squashing and an issued-instruction counter.
module ctrl_decode_pipe #(
    parameter int CMD_W     = 4,
    parameter int BR_SHADOW = 1,
    parameter int COND_EN   = 1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [3:0]       op_code,
    input  logic [1:0]       mode,
    input  logic             s_bit,
    input  logic [3:0]       cond,
    input  logic [3:0]       status,
    input  logic             hazard,
    input  logic             flush,
    output logic             out_valid,
    output logic             mem_r_en,
    output logic             mem_w_en,
    output logic             wb_en,
    output logic             b,
    output logic             s_out,
    output logic [CMD_W-1:0] exe_cmd,
    output logic             shadow_busy,
    output logic [CNT_W-1:0] issue_count
);

    localparam logic [3:0] SHADOW_INIT = 4'(BR_SHADOW);

    function automatic logic cond_pass(input logic [3:0] c, input logic [3:0] st);
        logic n, z, cf, v;
        logic r;
        n  = st[3];
        z  = st[2];
        cf = st[1];
        v  = st[0];
        case (c)
            4'b0000: r = z;
            4'b0001: r = !z;
            4'b0010: r = cf;
            4'b0011: r = !cf;
            4'b0100: r = n;
            4'b0101: r = !n;
            4'b0110: r = v;
            4'b0111: r = !v;
            4'b1000: r = cf && !z;
            4'b1001: r = !cf || z;
            4'b1010: r = (n == v);
            4'b1011: r = (n != v);
            4'b1100: r = !z && (n == v);
            4'b1101: r = z || (n != v);
            4'b1110: r = 1'b1;
            default: r = 1'b0;
        endcase
        return r;
    endfunction

    logic             dec_vld, dec_rd, dec_wr, dec_wb, dec_b, dec_s;
    logic [3:0]       dec_cmd;
    logic             cond_ok;

    logic             out_valid_q, out_valid_d;
    logic             mem_r_en_q, mem_r_en_d;
    logic             mem_w_en_q, mem_w_en_d;
    logic             wb_en_q, wb_en_d;
    logic             b_q, b_d;
    logic             s_out_q, s_out_d;
    logic [CMD_W-1:0] exe_cmd_q, exe_cmd_d;
    logic [3:0]       shadow_q, shadow_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        dec_vld = 1'b0;
        dec_rd  = 1'b0;
        dec_wr  = 1'b0;
        dec_wb  = 1'b0;
        dec_b   = 1'b0;
        dec_s   = 1'b0;
        dec_cmd = 4'b0000;
        case (mode)
            2'b00: begin
                dec_vld = 1'b1;
                dec_wb  = 1'b1;
                dec_s   = s_bit;
                case (op_code)
                    4'b1101: dec_cmd = 4'b0001;
                    4'b1111: dec_cmd = 4'b1001;
                    4'b0100: dec_cmd = 4'b0010;
                    4'b0101: dec_cmd = 4'b0011;
                    4'b0010: dec_cmd = 4'b0100;
                    4'b0110: dec_cmd = 4'b0101;
                    4'b0000: dec_cmd = 4'b0110;
                    4'b1100: dec_cmd = 4'b0111;
                    4'b0001: dec_cmd = 4'b1000;
                    4'b1010: begin dec_cmd = 4'b0100; dec_wb = 1'b0; end
                    4'b1000: begin dec_cmd = 4'b0110; dec_wb = 1'b0; end
                    default: begin dec_vld = 1'b0; dec_wb = 1'b0; dec_s = 1'b0; end
                endcase
            end
            2'b01: begin
                if (op_code == 4'b0100) begin
                    dec_vld = 1'b1;
                    dec_cmd = 4'b0010;
                    dec_rd  = s_bit;
                    dec_wb  = s_bit;
                    dec_wr  = !s_bit;
                end
            end
            2'b10: begin
                dec_vld = 1'b1;
                dec_b   = 1'b1;
            end
            default: ;
        endcase
    end

    assign cond_ok = (COND_EN == 0) || cond_pass(cond, status);

    // Priority chain: every early exit leaves the all-zero bubble in place.
    always_comb begin
        out_valid_d = 1'b0;
        mem_r_en_d  = 1'b0;
        mem_w_en_d  = 1'b0;
        wb_en_d     = 1'b0;
        b_d         = 1'b0;
        s_out_d     = 1'b0;
        exe_cmd_d   = '0;
        shadow_d    = shadow_q;
        if (flush) begin
            shadow_d = 4'd0;
        end else if (hazard || !in_valid) begin
            shadow_d = shadow_q;
        end else if (shadow_q != 4'd0) begin
            shadow_d = shadow_q - 4'd1;
        end else if (cond_ok && dec_vld) begin
            out_valid_d = 1'b1;
            mem_r_en_d  = dec_rd;
            mem_w_en_d  = dec_wr;
            wb_en_d     = dec_wb;
            b_d         = dec_b;
            s_out_d     = dec_s;
            exe_cmd_d   = CMD_W'(dec_cmd);
            if (dec_b) begin
                shadow_d = SHADOW_INIT;
            end
        end
        cnt_d = out_valid_d ? cnt_q + 1'b1 : cnt_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            mem_r_en_q  <= 1'b0;
            mem_w_en_q  <= 1'b0;
            wb_en_q     <= 1'b0;
            b_q         <= 1'b0;
            s_out_q     <= 1'b0;
            exe_cmd_q   <= '0;
            shadow_q    <= 4'd0;
            cnt_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            mem_r_en_q  <= mem_r_en_d;
            mem_w_en_q  <= mem_w_en_d;
            wb_en_q     <= wb_en_d;
            b_q         <= b_d;
            s_out_q     <= s_out_d;
            exe_cmd_q   <= exe_cmd_d;
            shadow_q    <= shadow_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign mem_r_en    = mem_r_en_q;
    assign mem_w_en    = mem_w_en_q;
    assign wb_en       = wb_en_q;
    assign b           = b_q;
    assign s_out       = s_out_q;
    assign exe_cmd     = exe_cmd_q;
    assign shadow_busy = (shadow_q != 4'd0);
    assign issue_count = cnt_q;

endmodule
